// File: rtl/mem_access_master.sv
// mem_access_master: requester side of the byte-wide memory port.
// Accepts 1- or 2-beat (big-endian) read/write requests on a valid/ready
// handshake, runs one memory beat per clock, then pulses resp_valid for a cycle.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_write, req_len               op (1=write) and length (0=1 beat, 1=2 beats)
//   req_addr, req_wdata              base address, write data (beat0 = [15:8])
//   resp_valid, resp_rdata           completion pulse, read data (beat0 -> [15:8])
//   resp_err                         only with MEM_ACC_BOUND_ERR_EN: 2-beat access at top address
//   mem_addr, mem_wdata, mem_we      memory drive
//   mem_rdata                        memory combinational read data
//
// Build option: define MEM_ACC_BOUND_ERR_EN to flag 2-beat requests that would
// wrap past the top of memory (second beat is suppressed instead of wrapping).
module mem_access_master #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_len,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  resp_valid,
  output logic [2*DATA_W-1:0]   resp_rdata,
`ifdef MEM_ACC_BOUND_ERR_EN
  output logic                  resp_err,
`endif
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t               state, next;
  logic [ADDR_W-1:0]    base;
  logic                 op_write;
  logic                 op_len;
  logic [2*DATA_W-1:0]  wdata;
  logic [ADDR_W-1:0]    last_addr;   // mem_addr hold value outside the beats
  logic [DATA_W-1:0]    last_wdata;
  logic                 bound_err;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = last_addr;
    mem_wdata  = last_wdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next = BEAT0;
      end
      BEAT0: begin
        mem_addr  = base;
        mem_wdata = wdata[2*DATA_W-1:DATA_W];
        mem_we    = op_write;
        next      = op_len ? BEAT1 : DONE;
      end
      BEAT1: begin
        mem_addr  = base + ADDR_W'(1);
        mem_wdata = wdata[DATA_W-1:0];
        mem_we    = op_write && !bound_err;
        next      = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        next       = IDLE;
      end
      default: next = IDLE;
    endcase
    // Reset kills the write strobe in the same cycle so the beat in flight
    // is not committed at the edge that applies the reset.
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base       <= '0;
      op_write   <= 1'b0;
      op_len     <= 1'b0;
      wdata      <= '0;
      resp_rdata <= '0;
      last_addr  <= '0;
      last_wdata <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        base     <= req_addr;
        op_write <= req_write;
        op_len   <= req_len;
        wdata    <= req_wdata;
        if (!req_write && !req_len) resp_rdata[DATA_W-1:0] <= '0;
      end
      if (state == BEAT0 || state == BEAT1) begin
        last_addr  <= mem_addr;
        last_wdata <= mem_wdata;
      end
      if (state == BEAT0 && !op_write) resp_rdata[2*DATA_W-1:DATA_W] <= mem_rdata;
      if (state == BEAT1 && !op_write)
        resp_rdata[DATA_W-1:0] <= bound_err ? '0 : mem_rdata;
    end
  end

`ifdef MEM_ACC_BOUND_ERR_EN
  // Flag a 2-beat request whose second beat would wrap past the top address.
  always_ff @(posedge clk) begin
    if (rst)                               bound_err <= 1'b0;
    else if (state == IDLE && req_valid)   bound_err <= req_len && (&req_addr);
  end
  assign resp_err = (state == DONE) && bound_err;
`else
  assign bound_err = 1'b0;
`endif

endmodule
